// File: rtl/cache_req_sync_bridge.sv
// Click-to-clocked request bridge: captures merge drive pulses as a toggle,
// synchronises it into clk, buffers requests in a FWFT FIFO and returns free pulses.
module cache_req_sync_bridge #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_drive,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                   req_tgl_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_tgl_r;
    logic [AW-1:0]          wptr_r;
    logic [AW-1:0]          rptr_r;
    logic [CW-1:0]          count_r;
    logic                   free_r;
    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

    logic                   req_sync_s;
    logic                   pending_s;
    logic                   valid_s;
    logic                   pop_s;
    logic                   push_s;

    // Request capture: a toggle in the drive domain so even very narrow pulses register.
    always_ff @(posedge i_drive or negedge rstn) begin
        if (!rstn) begin
            req_tgl_r <= 1'b0;
        end else begin
            req_tgl_r <= ~req_tgl_r;
        end
    end

    // Synchroniser chain bringing the request toggle into clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_tgl_r};
        end
    end

    // Handshake and FIFO flow decode; a full FIFO still accepts when popping.
    always_comb begin
        req_sync_s = sync_r[SYNC_STAGES-1];
        pending_s  = (req_sync_s != ack_tgl_r);
        valid_s    = (count_r != {CW{1'b0}});
        pop_s      = valid_s && i_ready;
        push_s     = pending_s && ((count_r < CW'(DEPTH)) || pop_s);
    end

    // Pointer, occupancy, acknowledge toggle and free-pulse state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_tgl_r <= 1'b0;
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            free_r    <= 1'b0;
        end else begin
            free_r <= push_s;
            if (push_s) begin
                wptr_r    <= wptr_r + AW'(1);
                ack_tgl_r <= ~ack_tgl_r;
            end else begin
                wptr_r    <= wptr_r;
                ack_tgl_r <= ack_tgl_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since o_valid qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= i_data;
        end
    end

    // Head data is forced to zero while empty so reset leaves o_data cleared.
    always_comb begin
        if (valid_s) begin
            o_data = mem_r[rptr_r];
        end else begin
            o_data = {DATA_WIDTH{1'b0}};
        end
    end

    assign o_valid   = valid_s;
    assign o_free    = free_r;
    assign o_count   = count_r;
    assign o_pending = pending_s;

endmodule

// File: tb/tb_cache_req_sync_bridge.sv
// Self-checking bench for cache_req_sync_bridge: random-offset drive pulses,
// scoreboard queue model of the FIFO, one task per scenario.
module tb_cache_req_sync_bridge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_drive = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_free;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_pending;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ready_mode = 0;   // 0 low, 1 high, 2 toggle every cycle
    int free_seen = 0;

    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] out_log[$];
    bit prev_pop = 1'b0;
    bit prev_free = 1'b0;

    cache_req_sync_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data),
        .o_free(o_free), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_count(o_count), .o_pending(o_pending)
    );

    initial forever #5 clk = ~clk;

    // Consumer ready pattern, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            1:       i_ready = 1'b1;
            2:       i_ready = ~i_ready;
            default: i_ready = 1'b0;
        endcase
    end

    // Scoreboard: a queue of accepted requests compared with the FIFO head every cycle.
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            sent_q.delete();
            model_q.delete();
            prev_pop = 1'b0;
            prev_free = 1'b0;
        end else begin
            if (prev_pop && model_q.size() != 0) out_log.push_back(model_q.pop_front());
            if (o_free) begin
                free_seen++;
                total_cnt++;
                if (sent_q.size() == 0) $display("FAIL unexpected_free got o_free=1 need 0");
                else begin pass_cnt++; model_q.push_back(sent_q.pop_front()); end
                total_cnt++;
                if (prev_free) $display("FAIL free_consecutive got 2 cycles need 1");
                else pass_cnt++;
            end
            total_cnt++;
            if (o_count !== CW'(model_q.size()))
                $display("FAIL count got %0d need %0d", o_count, model_q.size());
            else pass_cnt++;
            total_cnt++;
            if (o_valid !== (model_q.size() != 0))
                $display("FAIL valid got %0b need %0b", o_valid, model_q.size() != 0);
            else pass_cnt++;
            if (model_q.size() != 0) begin
                total_cnt++;
                if (o_data !== model_q[0]) $display("FAIL head_data got %0h need %0h", o_data, model_q[0]);
                else pass_cnt++;
            end
            prev_pop = o_valid && i_ready;
            prev_free = o_free;
        end
    end

    // Issue one drive pulse at a random offset after a falling edge; optionally wait for o_free.
    task automatic send(input logic [DW-1:0] d, input bit wait_free, input bit check_lat);
        int k;
        @(negedge clk);
        #($urandom_range(1, 3));
        i_data = d;
        sent_q.push_back(d);
        i_drive = 1'b1;
        #1 i_drive = 1'b0;
        if (wait_free) begin
            k = 0;
            while (k < 12) begin
                @(negedge clk);
                k++;
                if (o_free) break;
            end
            total_cnt++;
            if (!o_free) $display("FAIL free_timeout data %0h got none need o_free", d);
            else if (check_lat && (k < SS + 1 || k > SS + 2))
                $display("FAIL free_latency got %0d need %0d..%0d", k, SS + 1, SS + 2);
            else pass_cnt++;
        end
    endtask

    task automatic drain(input int budget);
        ready_mode = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_valid && model_q.size() == 0) break;
        end
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] first, input int n);
        total_cnt++;
        if (out_log.size() != n) $display("FAIL %s_len got %0d need %0d", name, out_log.size(), n);
        else pass_cnt++;
        for (int i = 0; i < n && i < out_log.size(); i++) begin
            total_cnt++;
            if (out_log[i] !== first + DW'(i))
                $display("FAIL %s_order[%0d] got %0h need %0h", name, i, out_log[i], first + DW'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({o_valid, o_count, o_free, o_pending, o_data} !== '0)
            $display("FAIL reset_outputs got v=%0b c=%0d f=%0b p=%0b d=%0h need all 0",
                     o_valid, o_count, o_free, o_pending, o_data);
        else pass_cnt++;
        @(negedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single();
        int vcyc;
        int f0;
        out_log.delete();
        ready_mode = 1;
        repeat (2) @(negedge clk);
        f0 = free_seen;
        send(8'hA5, 1'b1, 1'b1);
        vcyc = o_valid ? 1 : 0;
        total_cnt++;
        if (o_count !== CW'(1)) $display("FAIL single_count_peak got %0d need 1", o_count);
        else pass_cnt++;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) vcyc++;
        end
        total_cnt++;
        if (vcyc != 1) $display("FAIL single_valid_cycles got %0d need 1", vcyc);
        else pass_cnt++;
        total_cnt++;
        if (free_seen - f0 != 1) $display("FAIL single_free_pulses got %0d need 1", free_seen - f0);
        else pass_cnt++;
        check_log("single", 8'hA5, 1);
    endtask

    task automatic test_fill_release();
        int f0;
        int k;
        out_log.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        f0 = free_seen;
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b1, 1'b1);
        send(8'h05, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        total_cnt++;
        if (free_seen - f0 != 4) $display("FAIL fill_free_pulses got %0d need 4", free_seen - f0);
        else pass_cnt++;
        total_cnt++;
        if (o_count !== CW'(4) || o_pending !== 1'b1)
            $display("FAIL fill_full got count=%0d pending=%0b need count=4 pending=1", o_count, o_pending);
        else pass_cnt++;
        @(posedge clk);
        ready_mode = 1;
        k = 0;
        while (k < 6) begin
            @(negedge clk);
            k++;
            if (o_free) break;
        end
        total_cnt++;
        if (!o_free || k != 2) $display("FAIL release_free got negedge %0d free=%0b need negedge 2", k, o_free);
        else pass_cnt++;
        drain(30);
        check_log("release", 8'h01, 5);
    endtask

    task automatic test_wrap();
        out_log.delete();
        ready_mode = 2;
        for (int i = 0; i < 10; i++) send(8'h10 + DW'(i), 1'b1, 1'b0);
        drain(30);
        check_log("wrap", 8'h10, 10);
    endtask

    task automatic test_reset_mid();
        int f0;
        out_log.delete();
        ready_mode = 0;
        for (int i = 0; i < 3; i++) send(8'h20 + DW'(i), 1'b1, 1'b0);
        send(8'h23, 1'b0, 1'b0);
        f0 = free_seen;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        total_cnt++;
        if (o_count !== '0 || o_valid !== 1'b0 || o_pending !== 1'b0)
            $display("FAIL midreset_state got c=%0d v=%0b p=%0b need 0 0 0", o_count, o_valid, o_pending);
        else pass_cnt++;
        @(negedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (free_seen != f0 || o_pending !== 1'b0)
            $display("FAIL midreset_dropped got frees=%0d pending=%0b need 0 0", free_seen - f0, o_pending);
        else pass_cnt++;
        out_log.delete();
        ready_mode = 1;
        send(8'h3C, 1'b1, 1'b1);
        drain(20);
        check_log("after_reset", 8'h3C, 1);
    endtask

    task automatic test_random();
        logic [DW-1:0] base;
        out_log.delete();
        base = DW'($urandom_range(0, 200));
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            send(base + DW'(i), 1'b1, 1'b0);
        end
        drain(40);
        check_log("random", base, 8);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_release();
        test_wrap();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
